// File: rtl/execute_muldiv.sv
// Multi-cycle RV32M/RV64M multiply/divide unit sitting beside the ALU in execute.
// Shift-add multiply (MUL_BITS per cycle) and restoring divide share one 2*XLEN accumulator.
module execute_muldiv #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      function_select,
  input  logic [XLEN-1:0] input_a,
  input  logic [XLEN-1:0] input_b,
  input  logic            kill,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      state_dbg
);

  localparam int MUL_STEPS = XLEN / MUL_BITS;
  localparam int CNT_W     = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                done_q, done_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic [1:0]          op_q, op_d;

  // Operand decode: magnitudes and the sign the final result must carry.
  logic                a_signed, b_signed, sign_a, sign_b, neg_in;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic                div_by_zero, div_overflow, special_case;
  logic [XLEN-1:0]     special_val;

  always_comb begin
    a_signed     = (function_select == 3'd0) || (function_select == 3'd1) ||
                   (function_select == 3'd2) || (function_select == 3'd4) ||
                   (function_select == 3'd6);
    b_signed     = (function_select == 3'd0) || (function_select == 3'd1) ||
                   (function_select == 3'd4) || (function_select == 3'd6);
    sign_a       = a_signed && input_a[XLEN-1];
    sign_b       = b_signed && input_b[XLEN-1];
    mag_a        = sign_a ? -input_a : input_a;
    mag_b        = sign_b ? -input_b : input_b;
    neg_in       = (function_select == 3'd6) ? sign_a : (sign_a ^ sign_b);
    div_by_zero  = (input_b == '0);
    div_overflow = ((function_select == 3'd4) || (function_select == 3'd6)) &&
                   (input_a == {1'b1, {(XLEN-1){1'b0}}}) && (input_b == '1);
    special_case = function_select[2] && (div_by_zero || div_overflow);
    if (div_by_zero) special_val = function_select[1] ? input_a : '1;
    else             special_val = function_select[1] ? '0 : input_a;
  end

  // One iteration of either algorithm; the first iteration runs on the launch edge.
  logic                in_idle;
  logic [2*XLEN-1:0]   step_acc;
  logic [XLEN-1:0]     step_opnd;
  logic [XLEN+MUL_BITS-1:0] mul_sum;
  logic [2*XLEN-1:0]   mul_next, prod_fix;
  logic [XLEN:0]       div_shift, div_diff;
  logic                div_ok;
  logic [2*XLEN-1:0]   div_next;
  logic [XLEN-1:0]     quo, rem, mul_res, div_res;

  always_comb begin
    in_idle   = (state_q == S_IDLE);
    step_acc  = acc_q;
    step_opnd = opnd_q;
    if (in_idle) begin
      step_acc  = function_select[2] ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
      step_opnd = function_select[2] ? mag_b : mag_a;
    end
    mul_sum   = {{MUL_BITS{1'b0}}, step_acc[2*XLEN-1:XLEN]} +
                ({{MUL_BITS{1'b0}}, step_opnd} * {{XLEN{1'b0}}, step_acc[MUL_BITS-1:0]});
    mul_next  = {mul_sum, step_acc[XLEN-1:MUL_BITS]};
    div_shift = {step_acc[2*XLEN-1:XLEN], step_acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, step_opnd};
    div_ok    = ~div_diff[XLEN];
    div_next  = {(div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                 step_acc[XLEN-2:0], div_ok};
    prod_fix  = neg_q ? -mul_next : mul_next;
    mul_res   = (op_q == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    quo       = div_next[XLEN-1:0];
    rem       = div_next[2*XLEN-1:XLEN];
    if (op_q[1]) div_res = neg_q ? -rem : rem;
    else         div_res = neg_q ? -quo : quo;
  end

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    result_d = result_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    op_d     = op_q;
    if (kill) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_d  = function_select[1:0];
            neg_d = neg_in;
            if (special_case) begin
              result_d = special_val;
              done_d   = 1'b1;
              state_d  = S_FIN;
            end else if (function_select[2]) begin
              acc_d   = div_next;
              opnd_d  = mag_b;
              cnt_d   = CNT_W'(XLEN - 2);
              state_d = S_DIV;
            end else begin
              acc_d   = mul_next;
              opnd_d  = mag_a;
              cnt_d   = CNT_W'(MUL_STEPS - 2);
              state_d = S_MUL;
            end
          end
        end
        S_MUL: begin
          acc_d = mul_next;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            result_d = mul_res;
            done_d   = 1'b1;
            state_d  = S_FIN;
          end
        end
        S_DIV: begin
          acc_d = div_next;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            result_d = div_res;
            done_d   = 1'b1;
            state_d  = S_FIN;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      done_q   <= 1'b0;
      result_q <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      op_q     <= 2'b00;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      op_q     <= op_d;
    end
  end

  // done is high exactly while in FIN, so the pipeline advances on the FIN edge.
  assign done      = done_q;
  assign result    = result_q;
  assign stall_req = start && !done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed bench for execute_muldiv: three instances (32/1, 32/4, 64/1) sharing clock,
// reset, function_select and kill, each with its own start.
module tb_execute_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  fsel;
  logic        kill;
  logic [63:0] opa, opb;
  logic [2:0]  start_v;
  logic [2:0]  stall_v, done_v;
  logic [31:0] res0, res1;
  logic [63:0] res2;
  logic [1:0]  st0, st1, st2;

  int n_checks = 0;
  int n_err    = 0;
  int done_cnt[3] = '{0, 0, 0};
  int ops_cnt[3]  = '{0, 0, 0};

  // clock / reset
  always #5 clk = ~clk;

  execute_muldiv #(.XLEN(32), .MUL_BITS(1)) u_m32 (
    .clk(clk), .reset(reset), .start(start_v[0]), .function_select(fsel),
    .input_a(opa[31:0]), .input_b(opb[31:0]), .kill(kill),
    .stall_req(stall_v[0]), .done(done_v[0]), .result(res0), .state_dbg(st0));

  execute_muldiv #(.XLEN(32), .MUL_BITS(4)) u_m32q (
    .clk(clk), .reset(reset), .start(start_v[1]), .function_select(fsel),
    .input_a(opa[31:0]), .input_b(opb[31:0]), .kill(kill),
    .stall_req(stall_v[1]), .done(done_v[1]), .result(res1), .state_dbg(st1));

  execute_muldiv #(.XLEN(64), .MUL_BITS(1)) u_m64 (
    .clk(clk), .reset(reset), .start(start_v[2]), .function_select(fsel),
    .input_a(opa), .input_b(opb), .kill(kill),
    .stall_req(stall_v[2]), .done(done_v[2]), .result(res2), .state_dbg(st2));

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) done_cnt[i] += int'(done_v[i]);
  end

  function automatic logic [63:0] res_of(input int i);
    case (i)
      0:       return {32'h0, res0};
      1:       return {32'h0, res1};
      default: return res2;
    endcase
  endfunction

  function automatic logic [1:0] st_of(input int i);
    case (i)
      0:       return st0;
      1:       return st1;
      default: return st2;
    endcase
  endfunction

  // scoreboard
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks: latency counts the start cycle through the done cycle inclusive
  task automatic run_op(input int inst, input logic [2:0] fn, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_res,
                        input int exp_lat, input string tag);
    int   lat;
    int   cnt_before;
    logic stall_bad;
    @(negedge clk);
    fsel = fn;
    opa = a;
    opb = b;
    start_v = 3'b000;
    start_v[inst] = 1'b1;
    lat = 1;
    stall_bad = 1'b0;
    #1;
    cnt_before = done_cnt[inst];
    while (!done_v[inst] && lat < 100) begin
      if (!stall_v[inst]) stall_bad = 1'b1;
      @(negedge clk);
      #1;
      lat++;
    end
    check({tag, " done"}, {63'b0, done_v[inst]}, 64'd1);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " stall_busy"}, {63'b0, stall_bad}, 64'd0);
    check({tag, " stall_done"}, {63'b0, stall_v[inst]}, 64'd0);
    check({tag, " result"}, res_of(inst), exp_res);
    check({tag, " one_done"}, 64'(done_cnt[inst] - cnt_before), 64'd1);
    ops_cnt[inst]++;
  endtask

  task automatic release_start();
    @(negedge clk);
    start_v = 3'b000;
  endtask

  int cnt_save;

  initial begin
    reset = 1'b1;
    start_v = 3'b000;
    kill = 1'b0;
    fsel = 3'd0;
    opa = '0;
    opb = '0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset done%0d", i), {63'b0, done_v[i]}, 64'd0);
      check($sformatf("reset result%0d", i), res_of(i), 64'd0);
      check($sformatf("reset state%0d", i), {62'b0, st_of(i)}, 64'd0);
      check($sformatf("reset stall%0d", i), {63'b0, stall_v[i]}, 64'd0);
    end
    reset = 1'b0;

    // multiplies, one bit per cycle
    run_op(0, 3'd0, 64'h7,        64'hFFFFFFFD, 64'hFFFFFFEB, 33, "mul32");
    run_op(0, 3'd1, 64'h80000000, 64'h80000000, 64'h40000000, 33, "mulh32");
    run_op(0, 3'd2, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 33, "mulhsu32");
    run_op(0, 3'd3, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 33, "mulhu32");
    // multiplies, four bits per cycle
    run_op(1, 3'd0, 64'h7,        64'hFFFFFFFD, 64'hFFFFFFEB, 9, "mul32q");
    run_op(1, 3'd1, 64'h80000000, 64'h80000000, 64'h40000000, 9, "mulh32q");
    run_op(1, 3'd2, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 9, "mulhsu32q");
    run_op(1, 3'd3, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 9, "mulhu32q");
    // divides and the special cases
    run_op(0, 3'd4, 64'hFFFFFFF9, 64'h2,        64'hFFFFFFFD, 33, "div32");
    run_op(0, 3'd6, 64'hFFFFFFF9, 64'h2,        64'hFFFFFFFF, 33, "rem32");
    run_op(0, 3'd5, 64'h1234,     64'h0,        64'hFFFFFFFF, 2,  "divu_by0");
    run_op(0, 3'd7, 64'h1234,     64'h0,        64'h1234,     2,  "remu_by0");
    run_op(0, 3'd4, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 2,  "div_ovf");
    run_op(0, 3'd6, 64'h80000000, 64'hFFFFFFFF, 64'h0,        2,  "rem_ovf");
    run_op(0, 3'd5, 64'd100,      64'd7,        64'd14,       33, "divu32");
    run_op(0, 3'd7, 64'd100,      64'd7,        64'd2,        33, "remu32");
    release_start();

    // kill on the tenth cycle of a divide
    cnt_save = done_cnt[0];
    @(negedge clk);
    fsel = 3'd4;
    opa = 64'd1000;
    opb = 64'd3;
    start_v = 3'b001;
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    start_v = 3'b000;
    #1;
    check("kill state", {62'b0, st0}, 64'd0);
    check("kill done", {63'b0, done_v[0]}, 64'd0);
    check("kill result", {32'h0, res0}, 64'd2);
    run_op(0, 3'd0, 64'd3, 64'd5, 64'd15, 33, "mul_after_kill");
    release_start();
    check("kill no_extra_done", 64'(done_cnt[0] - cnt_save), 64'd1);

    // kill together with start in IDLE launches nothing
    cnt_save = done_cnt[0];
    @(negedge clk);
    fsel = 3'd0;
    opa = 64'd9;
    opb = 64'd9;
    start_v = 3'b001;
    kill = 1'b1;
    @(negedge clk);
    start_v = 3'b000;
    kill = 1'b0;
    #1;
    check("kill_start state", {62'b0, st0}, 64'd0);
    repeat (3) @(negedge clk);
    check("kill_start no_done", 64'(done_cnt[0] - cnt_save), 64'd0);
    check("kill_start result", {32'h0, res0}, 64'd15);

    // asynchronous reset in the middle of a multiply
    @(negedge clk);
    fsel = 3'd0;
    opa = 64'd3;
    opb = 64'd5;
    start_v = 3'b001;
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid done", {63'b0, done_v[0]}, 64'd0);
    check("rst_mid result", {32'h0, res0}, 64'd0);
    check("rst_mid state", {62'b0, st0}, 64'd0);
    @(negedge clk);
    start_v = 3'b000;
    reset = 1'b0;

    // back-to-back on the 64-bit unit
    run_op(2, 3'd0, 64'hFFFFFFFFFFFFFFFF, 64'd2, 64'hFFFFFFFFFFFFFFFE, 65, "mul64");
    run_op(2, 3'd5, 64'h8000000000000000, 64'd3, 64'h2AAAAAAAAAAAAAAA, 65, "divu64");
    release_start();

    repeat (4) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("done_total%0d", i), 64'(done_cnt[i]), 64'(ops_cnt[i]));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
